// File: rtl/store_buffer.sv
// Store queue between the CPU store port and data memory: formats SB/SH/SW into
// lane-replicated word writes. Optional macro STORE_MISALIGN_CHK_EN drops misaligned SH/SW.
module store_buffer #(
  parameter int DEPTH        = 4,
  parameter int CPU_WIDTH    = 32,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    st_valid_i,
  output logic                    st_ready_o,
  input  logic [CPU_WIDTH-1:0]    st_addr_i,
  input  logic [CPU_WIDTH-1:0]    st_data_i,
  input  logic [FUNCT3_WIDTH-1:0] funct3_i,
  output logic                    mem_req_o,
  input  logic                    mem_ack_i,
  output logic [CPU_WIDTH-1:0]    mem_addr_o,
  output logic [CPU_WIDTH-1:0]    mem_wdata_o,
  output logic [3:0]              mem_be_o,
  output logic                    empty_o
`ifdef STORE_MISALIGN_CHK_EN
  ,
  output logic                    misalign_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [FUNCT3_WIDTH-1:0] INST_SB = FUNCT3_WIDTH'(0);
  localparam logic [FUNCT3_WIDTH-1:0] INST_SH = FUNCT3_WIDTH'(1);
  localparam logic [FUNCT3_WIDTH-1:0] INST_SW = FUNCT3_WIDTH'(2);

  logic [CPU_WIDTH-3:0] addr_mem [DEPTH];
  logic [CPU_WIDTH-1:0] data_mem [DEPTH];
  logic [3:0]           be_mem   [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic                 is_store;
  logic                 bad_align;
  logic                 push;
  logic                 pop;
  logic [3:0]           be_d;
  logic [CPU_WIDTH-1:0] data_d;

  always_comb begin
    is_store = 1'b0;
    be_d     = 4'b0000;
    data_d   = '0;
    case (funct3_i)
      INST_SB: begin
        is_store = 1'b1;
        be_d     = 4'b0001 << st_addr_i[1:0];
        data_d   = {(CPU_WIDTH/8){st_data_i[7:0]}};
      end
      INST_SH: begin
        is_store = 1'b1;
        be_d     = st_addr_i[1] ? 4'b1100 : 4'b0011;
        data_d   = {(CPU_WIDTH/16){st_data_i[15:0]}};
      end
      INST_SW: begin
        is_store = 1'b1;
        be_d     = 4'b1111;
        data_d   = st_data_i;
      end
      default: ;
    endcase
  end

`ifdef STORE_MISALIGN_CHK_EN
  assign bad_align = ((funct3_i == INST_SH) && st_addr_i[0]) ||
                     ((funct3_i == INST_SW) && (st_addr_i[1:0] != 2'b00));
`else
  // Without the checker the low address bits are simply ignored for SH/SW.
  assign bad_align = 1'b0;
`endif

  assign st_ready_o = (count_q != CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign mem_req_o  = !empty_o;
  assign push       = st_valid_i && st_ready_o && is_store && !bad_align;
  assign pop        = mem_req_o && mem_ack_i;

  // Head entry is shown only while valid, so an empty queue presents all zeros.
  assign mem_addr_o  = empty_o ? '0 : {addr_mem[rd_ptr_q], 2'b00};
  assign mem_wdata_o = empty_o ? '0 : data_mem[rd_ptr_q];
  assign mem_be_o    = empty_o ? 4'b0000 : be_mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= st_addr_i[CPU_WIDTH-1:2];
      data_mem[wr_ptr_q] <= data_d;
      be_mem[wr_ptr_q]   <= be_d;
    end
  end

`ifdef STORE_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;

  assign misalign_d = st_valid_i && is_store && bad_align;
  assign misalign_o = misalign_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) misalign_q <= 1'b0;
    else       misalign_q <= misalign_d;
  end
`endif

endmodule
